mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle MIPS control sequencer: RST/FETCH/DECODE/EXEC/MEM/WB/TRAP FSM driving datapath enables and muxes.

---
 rtl/mips_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer with memory wait states, sticky prioritised IRQs and illegal-opcode trap.
// Optional IRQ_MASK_EN adds an irq_mask input gating which pending lines may trigger a trap.
module mips_multicycle_ctrl #(
    parameter int IRQ_NUM  = 4,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               pchigh,
    input  logic [IRQ_NUM-1:0] irq,
`ifdef IRQ_MASK_EN
    input  logic [IRQ_NUM-1:0] irq_mask,
`endif
    output logic               pc_wr,
    output logic [1:0]         pc_src,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic               ir_wr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               reg_wr,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src1,
    output logic               alu_src2,
    output logic [5:0]         alu_fun,
    output logic               sign,
    output logic               ext_op,
    output logic               lu_op,
    output logic [IRQ_NUM-1:0] irq_ack
);

    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [3:0] {C_RALU, C_IALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_JALR, C_ILL} iclass_t;

    typedef struct packed {
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       trap;
        logic [1:0] trap_cause;
        logic       ir_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src1;
        logic       alu_src2;
        logic [5:0] alu_fun;
        logic       sign;
        logic       ext_op;
        logic       lu_op;
    } ctrl_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT);
    localparam logic [5:0] F_ADD = 6'b000000, F_SUB = 6'b000001, F_AND = 6'b011000,
                           F_OR  = 6'b011110, F_XOR = 6'b010110, F_NOR = 6'b010001,
                           F_SLL = 6'b100000, F_SRL = 6'b100001, F_SRA = 6'b100011,
                           F_EQ  = 6'b110011, F_NEQ = 6'b110001, F_LT  = 6'b110101,
                           F_LEZ = 6'b111101, F_LTZ = 6'b111011, F_GTZ = 6'b111111;

    state_t             state_q, state_d;
    iclass_t            cls_q, cls_d, dec_cls;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IRQ_NUM-1:0] pend_q, pend_d, irq_ack_q, irq_ack_d;
    logic [IRQ_NUM-1:0] eligible, ack_sel;
    ctrl_t              ctrl_q, ctrl_d;
    logic [5:0]         dec_fun;
    logic               dec_src1, dec_src2, dec_sign, dec_ext, dec_lu;
    logic [1:0]         cause_d;
    logic               take_irq;

    always_comb begin
        dec_cls  = C_ILL;
        dec_fun  = F_ADD;
        dec_src1 = 1'b0;
        dec_src2 = 1'b0;
        dec_sign = 1'b0;
        dec_ext  = 1'b1;
        dec_lu   = 1'b1;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: begin dec_cls = C_RALU; dec_fun = F_SLL; dec_src1 = 1'b1; end
                    6'h02: begin dec_cls = C_RALU; dec_fun = F_SRL; dec_src1 = 1'b1; end
                    6'h03: begin dec_cls = C_RALU; dec_fun = F_SRA; dec_src1 = 1'b1; end
                    6'h08: dec_cls = C_JR;
                    6'h09: dec_cls = C_JALR;
                    6'h20: begin dec_cls = C_RALU; dec_fun = F_ADD; dec_sign = 1'b1; end
                    6'h21: begin dec_cls = C_RALU; dec_fun = F_ADD; end
                    6'h22: begin dec_cls = C_RALU; dec_fun = F_SUB; dec_sign = 1'b1; end
                    6'h23: begin dec_cls = C_RALU; dec_fun = F_SUB; end
                    6'h24: begin dec_cls = C_RALU; dec_fun = F_AND; end
                    6'h25: begin dec_cls = C_RALU; dec_fun = F_OR;  end
                    6'h26: begin dec_cls = C_RALU; dec_fun = F_XOR; end
                    6'h27: begin dec_cls = C_RALU; dec_fun = F_NOR; end
                    6'h2a: begin dec_cls = C_RALU; dec_fun = F_LT; dec_sign = 1'b1; end
                    6'h2b: begin dec_cls = C_RALU; dec_fun = F_LT; end
                    default: ;
                endcase
            end
            6'h01: begin dec_cls = C_BR; dec_fun = F_LTZ; dec_sign = 1'b1; end
            6'h02: dec_cls = C_J;
            6'h03: dec_cls = C_JAL;
            6'h04: begin dec_cls = C_BR; dec_fun = F_EQ;  dec_sign = 1'b1; end
            6'h05: begin dec_cls = C_BR; dec_fun = F_NEQ; dec_sign = 1'b1; end
            6'h06: begin dec_cls = C_BR; dec_fun = F_LEZ; dec_sign = 1'b1; end
            6'h07: begin dec_cls = C_BR; dec_fun = F_GTZ; dec_sign = 1'b1; end
            6'h08: begin dec_cls = C_IALU; dec_src2 = 1'b1; dec_sign = 1'b1; end
            6'h09: begin dec_cls = C_IALU; dec_src2 = 1'b1; end
            6'h0a: begin dec_cls = C_IALU; dec_fun = F_LT; dec_src2 = 1'b1; dec_sign = 1'b1; end
            6'h0b: begin dec_cls = C_IALU; dec_fun = F_LT; dec_src2 = 1'b1; end
            6'h0c: begin dec_cls = C_IALU; dec_fun = F_AND; dec_src2 = 1'b1; dec_ext = 1'b0; end
            6'h0f: begin dec_cls = C_IALU; dec_src2 = 1'b1; dec_lu = 1'b0; end
            6'h23: begin dec_cls = C_LW; dec_src2 = 1'b1; end
            6'h2b: begin dec_cls = C_SW; dec_src2 = 1'b1; end
            default: ;
        endcase
    end

`ifdef IRQ_MASK_EN
    assign eligible = pend_q & irq_mask;
`else
    assign eligible = pend_q;
`endif
    assign take_irq = !pchigh && (|eligible);
    assign ack_sel  = eligible & (~eligible + 1'b1);

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        cnt_d     = '0;
        cause_d   = 2'b00;
        pend_d    = (pend_q | irq) & ~irq_ack_q;
        ctrl_d    = '0;
        irq_ack_d = '0;

        unique case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (cnt_q == LAST) state_d = S_DECODE; else cnt_d = cnt_q + 1'b1;
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == C_ILL) begin
                    state_d = pchigh ? S_FETCH : S_TRAP;
                    cause_d = pchigh ? 2'b00 : 2'b10;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls_q == C_LW || cls_q == C_SW)        state_d = S_MEM;
                else if (cls_q == C_RALU || cls_q == C_IALU) state_d = S_WB;
                else begin
                    state_d = take_irq ? S_TRAP : S_FETCH;
                    cause_d = take_irq ? 2'b01 : 2'b00;
                end
            end
            S_MEM: begin
                if (cnt_q != LAST)     cnt_d   = cnt_q + 1'b1;
                else if (cls_q == C_LW) state_d = S_WB;
                else begin
                    state_d = take_irq ? S_TRAP : S_FETCH;
                    cause_d = take_irq ? 2'b01 : 2'b00;
                end
            end
            S_WB: begin
                state_d = take_irq ? S_TRAP : S_FETCH;
                cause_d = take_irq ? 2'b01 : 2'b00;
            end
            S_TRAP:   state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase

        unique case (state_d)
            S_FETCH: begin
                ctrl_d.mem_rd = 1'b1;
                if (cnt_d == LAST) begin
                    ctrl_d.ir_wr = 1'b1;
                    ctrl_d.pc_wr = 1'b1;
                end
            end
            S_EXEC: begin
                ctrl_d.alu_fun  = dec_fun;
                ctrl_d.alu_src1 = dec_src1;
                ctrl_d.alu_src2 = dec_src2;
                ctrl_d.sign     = dec_sign;
                ctrl_d.ext_op   = dec_ext;
                ctrl_d.lu_op    = dec_lu;
                case (dec_cls)
                    C_BR: begin ctrl_d.pc_wr = 1'b1; ctrl_d.pc_src = 2'b01; end
                    C_J:  begin ctrl_d.pc_wr = 1'b1; ctrl_d.pc_src = 2'b10; end
                    C_JR: begin ctrl_d.pc_wr = 1'b1; ctrl_d.pc_src = 2'b11; end
                    C_JAL, C_JALR: begin
                        ctrl_d.pc_wr      = 1'b1;
                        ctrl_d.pc_src     = (dec_cls == C_JAL) ? 2'b10 : 2'b11;
                        ctrl_d.reg_wr     = 1'b1;
                        ctrl_d.reg_dst    = 2'b10;
                        ctrl_d.mem_to_reg = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl_d.mem_rd = (cls_d == C_LW);
                ctrl_d.mem_wr = (cls_d == C_SW);
            end
            S_WB: begin
                ctrl_d.reg_wr     = 1'b1;
                ctrl_d.reg_dst    = (cls_d == C_RALU) ? 2'b00 : 2'b01;
                ctrl_d.mem_to_reg = (cls_d == C_LW) ? 2'b01 : 2'b00;
            end
            S_TRAP: begin
                ctrl_d.trap       = 1'b1;
                ctrl_d.trap_cause = cause_d;
                ctrl_d.pc_wr      = 1'b1;
                ctrl_d.reg_wr     = 1'b1;
                ctrl_d.reg_dst    = 2'b11;
                ctrl_d.mem_to_reg = 2'b10;
                irq_ack_d         = (cause_d == 2'b01) ? ack_sel : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            cls_q     <= C_ILL;
            cnt_q     <= '0;
            pend_q    <= '0;
            ctrl_q    <= '0;
            irq_ack_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ctrl_q    <= ctrl_d;
            irq_ack_q <= irq_ack_d;
        end
    end

    assign pc_wr      = ctrl_q.pc_wr;
    assign pc_src     = ctrl_q.pc_src;
    assign trap       = ctrl_q.trap;
    assign trap_cause = ctrl_q.trap_cause;
    assign ir_wr      = ctrl_q.ir_wr;
    assign mem_rd     = ctrl_q.mem_rd;
    assign mem_wr     = ctrl_q.mem_wr;
    assign reg_wr     = ctrl_q.reg_wr;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src1   = ctrl_q.alu_src1;
    assign alu_src2   = ctrl_q.alu_src2;
    assign alu_fun    = ctrl_q.alu_fun;
    assign sign       = ctrl_q.sign;
    assign ext_op     = ctrl_q.ext_op;
    assign lu_op      = ctrl_q.lu_op;
    assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: one instance with MEM_WAIT=1 and one with MEM_WAIT=3 share inputs.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       pchigh;
    logic [3:0] irq;

    logic       pc_wr, trap, ir_wr, mem_rd, mem_wr, reg_wr, alu_src1, alu_src2, sign, ext_op, lu_op;
    logic [1:0] pc_src, trap_cause, reg_dst, mem_to_reg;
    logic [5:0] alu_fun;
    logic [3:0] irq_ack;

    logic       pc_wr_3, trap_3, ir_wr_3, mem_rd_3, mem_wr_3, reg_wr_3, alu_src1_3, alu_src2_3;
    logic       sign_3, ext_op_3, lu_op_3;
    logic [1:0] pc_src_3, trap_cause_3, reg_dst_3, mem_to_reg_3;
    logic [5:0] alu_fun_3;
    logic [3:0] irq_ack_3;

    logic [28:0] allOut, allOut3;
    int compared = 0;
    int mismatched = 0;

    assign allOut  = {pc_wr, pc_src, trap, trap_cause, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst,
                      mem_to_reg, alu_src1, alu_src2, alu_fun, sign, ext_op, lu_op, irq_ack};
    assign allOut3 = {pc_wr_3, pc_src_3, trap_3, trap_cause_3, ir_wr_3, mem_rd_3, mem_wr_3, reg_wr_3,
                      reg_dst_3, mem_to_reg_3, alu_src1_3, alu_src2_3, alu_fun_3, sign_3, ext_op_3,
                      lu_op_3, irq_ack_3};

    mips_multicycle_ctrl #(.IRQ_NUM(4), .MEM_WAIT(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .pchigh(pchigh), .irq(irq),
`ifdef IRQ_MASK_EN
        .irq_mask(4'b1111),
`endif
        .pc_wr(pc_wr), .pc_src(pc_src), .trap(trap), .trap_cause(trap_cause), .ir_wr(ir_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_fun(alu_fun), .sign(sign), .ext_op(ext_op),
        .lu_op(lu_op), .irq_ack(irq_ack)
    );

    mips_multicycle_ctrl #(.IRQ_NUM(4), .MEM_WAIT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .pchigh(pchigh), .irq(irq),
`ifdef IRQ_MASK_EN
        .irq_mask(4'b1111),
`endif
        .pc_wr(pc_wr_3), .pc_src(pc_src_3), .trap(trap_3), .trap_cause(trap_cause_3), .ir_wr(ir_wr_3),
        .mem_rd(mem_rd_3), .mem_wr(mem_wr_3), .reg_wr(reg_wr_3), .reg_dst(reg_dst_3),
        .mem_to_reg(mem_to_reg_3), .alu_src1(alu_src1_3), .alu_src2(alu_src2_3), .alu_fun(alu_fun_3),
        .sign(sign_3), .ext_op(ext_op_3), .lu_op(lu_op_3), .irq_ack(irq_ack_3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic pch,
                                 input logic [3:0] irqv);
        opcode = op;
        funct  = fn;
        pchigh = pch;
        irq    = irqv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle numbers in the comments count edges after the most recent reset release.
    initial begin
        logic expRd, expRd3;
        rst_n = 1'b0;
        applyStimulus(6'h00, 6'h21, 1'b0, 4'b0000);
        repeat (3) tick();
        checkOutput("rst_all", 32'(allOut), 32'd0);
        checkOutput("rst_all3", 32'(allOut3), 32'd0);
        rst_n = 1'b1;

        // addu with MEM_WAIT=1
        tick(); // c1 FETCH 0
        checkOutput("add_f0", 32'({mem_rd, ir_wr, pc_wr}), 32'(3'b100));
        tick(); // c2 FETCH 1
        checkOutput("add_f1", 32'({ir_wr, pc_wr, pc_src, mem_rd}), 32'(5'b11001));
        tick(); // c3 DECODE
        checkOutput("add_dec_idle", 32'(allOut), 32'd0);
        tick(); // c4 EXEC
        checkOutput("add_exec", 32'({alu_fun, sign, alu_src1, alu_src2, ext_op, lu_op, reg_wr}),
                    32'({6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));
        tick(); // c5 WB
        checkOutput("add_wb", 32'({reg_wr, reg_dst, mem_to_reg, mem_rd}), 32'(6'b100000));
        tick(); // c6 FETCH 0
        checkOutput("add_next_fetch", 32'({mem_rd, trap}), 32'(2'b10));

        // irq 0110 pulsed for one cycle in the middle of the next addu
        tick(); // c7
        irq = 4'b0110;
        tick(); // c8 DECODE
        irq = 4'b0000;
        repeat (2) tick(); // c10 WB
        checkOutput("irq_wb_first", 32'({reg_wr, trap}), 32'(2'b10));
        tick(); // c11 TRAP
        checkOutput("irq1_trap", 32'({trap, pc_wr, reg_wr, reg_dst, mem_to_reg, trap_cause}),
                    32'(9'b1_1_1_11_10_01));
        checkOutput("irq1_ack", 32'(irq_ack), 32'(4'b0010));
        tick(); // c12 FETCH
        checkOutput("irq1_ack_pulse", 32'({irq_ack, trap, mem_rd}), 32'(6'b0000_0_1));
        repeat (5) tick(); // c17 TRAP
        checkOutput("irq2_ack", 32'({trap, trap_cause, irq_ack}), 32'(7'b1_01_0100));

        // illegal opcode in user mode, then in kernel mode
        opcode = 6'h3f;
        repeat (4) tick(); // c21 TRAP
        checkOutput("ill_trap", 32'({trap, trap_cause, reg_dst, reg_wr, irq_ack}),
                    32'({1'b1, 2'b10, 2'b11, 1'b1, 4'b0000}));
        pchigh = 1'b1;
        repeat (3) tick(); // c24 DECODE
        checkOutput("ill_kernel_dec", 32'(allOut), 32'd0);
        tick(); // c25 FETCH
        checkOutput("ill_kernel_nop", 32'({trap, reg_wr, mem_rd, ir_wr}), 32'(4'b0010));

        // irq[0] held while in kernel mode, then kernel mode drops
        applyStimulus(6'h00, 6'h21, 1'b1, 4'b0001);
        repeat (5) tick(); // c30 FETCH
        checkOutput("kern_no_trap", 32'({trap, mem_rd, irq_ack}), 32'(6'b0_1_0000));
        pchigh = 1'b0;
        repeat (5) tick(); // c35 TRAP
        checkOutput("user_trap", 32'({trap, trap_cause, irq_ack}), 32'(7'b1_01_0001));
        irq = 4'b0000;
        repeat (6) tick(); // c41 FETCH, ack cleared the pending bit
        checkOutput("irq_cleared", 32'({trap, mem_rd}), 32'(2'b01));

        // sw interrupted by asynchronous reset during MEM
        opcode = 6'h2b;
        repeat (3) tick(); // c44 EXEC
        checkOutput("sw_exec", 32'({alu_src2, alu_fun, mem_wr, mem_rd}), 32'(9'b1_000000_0_0));
        tick(); // c45 MEM 0
        checkOutput("sw_mem", 32'({mem_wr, mem_rd}), 32'(2'b10));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("sw_async_rst", 32'(allOut), 32'd0);
        checkOutput("sw_async_rst3", 32'(allOut3), 32'd0);

        // lw on both instances, then jal and beq on the MEM_WAIT=1 instance
        applyStimulus(6'h23, 6'h00, 1'b0, 4'b0000);
        tick();
        checkOutput("rst_hold", 32'(allOut), 32'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            expRd3 = (c <= 4) || (c >= 7 && c <= 10) || (c == 12);
            expRd  = (c <= 2) || (c == 5) || (c == 6) || (c == 8) || (c == 9) || (c == 12);
            checkOutput($sformatf("lw3_memrd_c%0d", c), 32'(mem_rd_3), 32'(expRd3));
            checkOutput($sformatf("lw3_irwr_c%0d", c), 32'(ir_wr_3), 32'(c == 4));
            checkOutput($sformatf("lw3_regwr_c%0d", c), 32'(reg_wr_3), 32'(c == 11));
            checkOutput($sformatf("lw1_memrd_c%0d", c), 32'(mem_rd), 32'(expRd));
            if (c == 6)  checkOutput("lw3_exec", 32'({alu_src2_3, alu_fun_3}), 32'(7'b1_000000));
            if (c == 7)  checkOutput("lw1_wb", 32'({reg_wr, reg_dst, mem_to_reg}), 32'(5'b1_01_01));
            if (c == 8)  opcode = 6'h03;
            if (c == 11) checkOutput("lw3_wb", 32'({reg_dst_3, mem_to_reg_3}), 32'(4'b01_01));
            if (c == 11) checkOutput("jal_exec", 32'({pc_wr, pc_src, reg_wr, reg_dst, mem_to_reg}),
                                     32'(8'b1_10_1_10_10));
            if (c == 12) opcode = 6'h04;
        end
        repeat (3) tick(); // c15 EXEC beq
        checkOutput("beq_exec", 32'({pc_wr, pc_src, alu_fun, reg_wr}), 32'({1'b1, 2'b01, 6'b110011, 1'b0}));

        // sll then andi
        applyStimulus(6'h00, 6'h00, 1'b0, 4'b0000);
        repeat (4) tick(); // c19 EXEC sll
        checkOutput("sll_exec", 32'({alu_src1, alu_src2, alu_fun}), 32'(8'b1_0_100000));
        tick(); // c20 WB
        checkOutput("sll_wb", 32'({reg_wr, reg_dst}), 32'(3'b100));
        opcode = 6'h0c;
        repeat (4) tick(); // c24 EXEC andi
        checkOutput("andi_exec", 32'({ext_op, lu_op, alu_src2, alu_fun}), 32'(9'b0_1_1_011000));
        tick(); // c25 WB
        checkOutput("andi_wb", 32'({reg_wr, reg_dst, mem_to_reg}), 32'(5'b1_01_00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
